seq_divider: RTL and testbench

Parametrised iterative integer divider, successor to the single-mode `divider`. Adds signed/unsigned mode, remainder output, radix-2^K iteration and explicit divide-by-zero and overflow flags. Used by the ALU path for per-thread DIV/REM instructions. Uses a start/done handshake with a busy indicator and fixed, documented latency.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_radix_step.sv | 30 +++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    FIN
  } div_state_e;

  // Divide-by-zero quotient is all ones (fill bit replicated to N).
  localparam logic DBZ_Q_FILL = 1'b1;

  function automatic int unsigned div_latency(input int unsigned n, input int unsigned k);
    return (n / k) + 3;
  endfunction

  function automatic int unsigned div_cnt_width(input int unsigned n, input int unsigned k);
    return ((n / k) > 1) ? $clog2(n / k) : 1;
  endfunction

endpackage

// File: rtl/div_radix_step.sv
// K restoring-division steps per call, MSB of shift_bits consumed first.
module div_radix_step #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 1
) (
  input  logic [N:0]   rem_in,
  input  logic [K-1:0] shift_bits,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic [K-1:0] q_bits
);

  logic [N:0]   rem_v;
  logic [N+1:0] diff;

  // Extra top bit of diff is the trial-subtract borrow.
  always_comb begin
    rem_v  = rem_in;
    diff   = '0;
    q_bits = '0;
    for (int i = K - 1; i >= 0; i--) begin
      rem_v     = {rem_v[N-1:0], shift_bits[i]};
      diff      = {1'b0, rem_v} - {2'b00, divisor};
      q_bits[i] = ~diff[N+1];
      if (!diff[N+1]) rem_v = diff[N:0];
    end
    rem_out = rem_v;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider with remainder, radix-2^K retirement
// and divide-by-zero / signed-overflow flags.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned K            = 1,
  parameter int unsigned verbose_flag = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned KS    = (K == 0) ? 1 : K;
  localparam int unsigned ITERS = N / KS;
  localparam int unsigned CNT_W = div_cnt_width(N, KS);
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  if ((K == 0) || (N < 2) || ((N % KS) != 0)) begin : g_bad_geometry
    $error("seq_divider: need N >= 2 and N divisible by K");
  end
  if (verbose_flag > 1) begin : g_bad_verbose
    $error("seq_divider: verbose_flag must be 0 or 1");
  end

  div_state_e state, state_nxt;
  logic       busy_nxt, done_nxt;

  logic             sm_q, dbz_q, ovf_q, neg_q_q, neg_r_q;
  logic [N-1:0]     acc_q;   // dividend in, quotient shifted in from the bottom
  logic [N-1:0]     dvs_q;
  logic [N:0]       rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N:0]       rem_step;
  logic [K-1:0]     q_step;

  div_radix_step #(.N(N), .K(K)) u_step (
    .rem_in    (rem_q),
    .shift_bits(acc_q[N-1 -: K]),
    .divisor   (dvs_q),
    .rem_out   (rem_step),
    .q_bits    (q_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Divide-by-zero takes one busy cycle through FIX so done lands in cycle 2.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? FIX : PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt_q == '0) state_nxt = FIX;
      FIX:     state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == PREP) || (state_nxt == ITER) || (state_nxt == FIX);
    done_nxt = (state_nxt == FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sm_q        <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      acc_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc_q <= dividend;
          dvs_q <= divisor;
          sm_q  <= signed_mode;
          dbz_q <= (divisor == '0);
          ovf_q <= signed_mode && (dividend == SMIN) && (divisor == '1);
        end
        PREP: begin
          neg_q_q <= (sm_q & acc_q[N-1]) ^ (sm_q & dvs_q[N-1]);
          neg_r_q <= sm_q & acc_q[N-1];
          acc_q   <= (sm_q && acc_q[N-1]) ? -acc_q : acc_q;
          dvs_q   <= (sm_q && dvs_q[N-1]) ? -dvs_q : dvs_q;
          rem_q   <= '0;
          cnt_q   <= CNT_W'(ITERS - 1);
        end
        ITER: begin
          acc_q <= (acc_q << K) | N'(q_step);
          rem_q <= rem_step;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        // On the divide-by-zero path acc_q still holds the raw dividend.
        FIX: begin
          quotient    <= dbz_q ? {N{DBZ_Q_FILL}} : (neg_q_q ? -acc_q : acc_q);
          remainder   <= dbz_q ? acc_q : (neg_r_q ? -rem_q[N-1:0] : rem_q[N-1:0]);
          div_by_zero <= dbz_q;
          overflow    <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider for N=8 (K=1,2) and N=4 (K=1,2,4).
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8, sm8;
  logic [7:0] a8, b8;
  logic       busy8 [2];
  logic       done8 [2];
  logic       dbz8  [2];
  logic       ovf8  [2];
  logic [7:0] q8    [2];
  logic [7:0] r8    [2];

  logic       start4, sm4;
  logic [3:0] a4, b4;
  logic       busy4 [3];
  logic       done4 [3];
  logic       dbz4  [3];
  logic       ovf4  [3];
  logic [3:0] q4    [3];
  logic [3:0] r4    [3];

  seq_divider #(.N(8), .K(1), .verbose_flag(0)) u_n8k1 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8), .dividend(a8), .divisor(b8),
    .busy(busy8[0]), .done(done8[0]), .quotient(q8[0]), .remainder(r8[0]),
    .div_by_zero(dbz8[0]), .overflow(ovf8[0]));
  seq_divider #(.N(8), .K(2), .verbose_flag(0)) u_n8k2 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8), .dividend(a8), .divisor(b8),
    .busy(busy8[1]), .done(done8[1]), .quotient(q8[1]), .remainder(r8[1]),
    .div_by_zero(dbz8[1]), .overflow(ovf8[1]));
  seq_divider #(.N(4), .K(1), .verbose_flag(0)) u_n4k1 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4), .dividend(a4), .divisor(b4),
    .busy(busy4[0]), .done(done4[0]), .quotient(q4[0]), .remainder(r4[0]),
    .div_by_zero(dbz4[0]), .overflow(ovf4[0]));
  seq_divider #(.N(4), .K(2), .verbose_flag(0)) u_n4k2 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4), .dividend(a4), .divisor(b4),
    .busy(busy4[1]), .done(done4[1]), .quotient(q4[1]), .remainder(r4[1]),
    .div_by_zero(dbz4[1]), .overflow(ovf4[1]));
  seq_divider #(.N(4), .K(4), .verbose_flag(0)) u_n4k4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4), .dividend(a4), .divisor(b4),
    .busy(busy4[2]), .done(done4[2]), .quotient(q4[2]), .remainder(r4[2]),
    .div_by_zero(dbz4[2]), .overflow(ovf4[2]));

  int checks = 0;
  int errors = 0;

  int         lat8 [2];
  logic [7:0] gq8  [2];
  logic [7:0] gr8  [2];
  logic       gz8  [2];
  logic       go8  [2];
  logic       bb8  [2];

  int         lat4 [3];
  logic [3:0] gq4  [3];
  logic [3:0] gr4  [3];
  logic       gz4  [3];
  logic       go4  [3];
  logic       bb4  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one op on both N=8 units, optionally poke start at cycle 'poke', capture at done.
  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b, input int poke);
    for (int i = 0; i < 2; i++) begin lat8[i] = 0; bb8[i] = 1'b0; end
    @(negedge clk); start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1; start8 = 1'b0; sm8 = ~sm; a8 = ~a; b8 = 8'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      start8 = (c == poke);
      if (c == poke) begin a8 = 8'd9; b8 = 8'd3; end
      for (int i = 0; i < 2; i++) begin
        if (lat8[i] == 0) begin
          if (done8[i]) begin
            lat8[i] = c; gq8[i] = q8[i]; gr8[i] = r8[i]; gz8[i] = dbz8[i]; go8[i] = ovf8[i];
            if (busy8[i]) bb8[i] = 1'b1;
          end else if (!busy8[i]) bb8[i] = 1'b1;
        end
      end
      if (lat8[0] != 0 && lat8[1] != 0) break;
    end
    start8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] eq, input logic [7:0] er,
                        input logic ez, input logic eo, input int el0, input int el1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s[%0d].quotient", tag, i), 32'(gq8[i]), 32'(eq));
      chk($sformatf("%s[%0d].remainder", tag, i), 32'(gr8[i]), 32'(er));
      chk($sformatf("%s[%0d].div_by_zero", tag, i), 32'(gz8[i]), 32'(ez));
      chk($sformatf("%s[%0d].overflow", tag, i), 32'(go8[i]), 32'(eo));
      chk($sformatf("%s[%0d].latency", tag, i), 32'(lat8[i]), 32'((i == 0) ? el0 : el1));
      chk($sformatf("%s[%0d].busy_profile", tag, i), 32'(bb8[i]), 32'd0);
    end
  endtask

  task automatic run4(input logic sm, input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 3; i++) begin lat4[i] = 0; bb4[i] = 1'b0; end
    @(negedge clk); start4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
    @(posedge clk); #1; start4 = 1'b0; sm4 = ~sm; a4 = 4'($urandom); b4 = 4'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      for (int i = 0; i < 3; i++) begin
        if (lat4[i] == 0) begin
          if (done4[i]) begin
            lat4[i] = c; gq4[i] = q4[i]; gr4[i] = r4[i]; gz4[i] = dbz4[i]; go4[i] = ovf4[i];
            if (busy4[i]) bb4[i] = 1'b1;
          end else if (!busy4[i]) bb4[i] = 1'b1;
        end
      end
      if (lat4[0] != 0 && lat4[1] != 0 && lat4[2] != 0) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int         seen;
    int         sa, sb;
    logic [3:0] eq, er, inv;
    logic       ez, eo;

    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset[%0d].busy", i), 32'(busy8[i]), 32'd0);
      chk($sformatf("reset[%0d].done", i), 32'(done8[i]), 32'd0);
      chk($sformatf("reset[%0d].quotient", i), 32'(q8[i]), 32'd0);
      chk($sformatf("reset[%0d].remainder", i), 32'(r8[i]), 32'd0);
      chk($sformatf("reset[%0d].div_by_zero", i), 32'(dbz8[i]), 32'd0);
      chk($sformatf("reset[%0d].overflow", i), 32'(ovf8[i]), 32'd0);
    end
    @(negedge clk); reset = 1'b1;

    run8(1'b0, 8'd200, 8'd7, 0);
    check8("u200div7", 8'd28, 8'd4, 1'b0, 1'b0, 11, 7);
    chk("done_one_cycle", 32'(done8[0]), 32'd0);
    run8(1'b1, 8'hF9, 8'h02, 0);
    check8("s_m7div2", 8'hFD, 8'hFF, 1'b0, 1'b0, 11, 7);
    run8(1'b1, 8'h07, 8'hFE, 0);
    check8("s_7divm2", 8'hFD, 8'h01, 1'b0, 1'b0, 11, 7);
    run8(1'b1, 8'h80, 8'hFF, 0);
    check8("s_overflow", 8'h80, 8'h00, 1'b0, 1'b1, 11, 7);
    run8(1'b0, 8'h80, 8'hFF, 0);
    check8("u_80divFF", 8'h00, 8'h80, 1'b0, 1'b0, 11, 7);
    run8(1'b1, 8'h5A, 8'h00, 0);
    check8("s_dbz", 8'hFF, 8'h5A, 1'b1, 1'b0, 2, 2);
    run8(1'b0, 8'h5A, 8'h00, 0);
    check8("u_dbz", 8'hFF, 8'h5A, 1'b1, 1'b0, 2, 2);
    run8(1'b0, 8'd200, 8'd7, 4);
    check8("start_while_busy", 8'd28, 8'd4, 1'b0, 1'b0, 11, 7);

    // Reset in ITER: outputs clear at once and no done follows.
    @(negedge clk); start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd7;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort[%0d].busy", i), 32'(busy8[i]), 32'd0);
      chk($sformatf("abort[%0d].quotient", i), 32'(q8[i]), 32'd0);
      chk($sformatf("abort[%0d].remainder", i), 32'(r8[i]), 32'd0);
      chk($sformatf("abort[%0d].flags", i), 32'({dbz8[i], ovf8[i], done8[i]}), 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8[0] || done8[1] || busy8[0] || busy8[1]) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run8(1'b1, 8'hF9, 8'h02, 0);
    check8("after_reset", 8'hFD, 8'hFF, 1'b0, 1'b0, 11, 7);

    // start held through the FIN cycle is ignored there, accepted the cycle after.
    @(negedge clk); start8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd10;
    @(posedge clk); #1; start8 = 1'b0;
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done8[0]) begin seen = c; break; end
      @(posedge clk); #1;
    end
    chk("fin_probe.latency", 32'(seen), 32'd11);
    chk("fin_probe.quotient", 32'(q8[0]), 32'd10);
    start8 = 1'b1; a8 = 8'd50; b8 = 8'd7;
    @(posedge clk); #1;
    chk("fin_start_ignored", 32'(busy8[0]), 32'd0);
    @(posedge clk); #1;
    chk("idle_start_accepted", 32'(busy8[0]), 32'd1);
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("idle_start.quotient", 32'(q8[0]), 32'd7);
    chk("idle_start.remainder", 32'(r8[0]), 32'd1);

    // Exhaustive N=4 sweep against an integer reference.
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          run4(1'(s), 4'(ai), 4'(bi));
          sa = (s != 0 && ai >= 8) ? ai - 16 : ai;
          sb = (s != 0 && bi >= 8) ? bi - 16 : bi;
          if (bi == 0) begin
            eq = 4'hF; er = 4'(ai); ez = 1'b1; eo = 1'b0;
          end else if (s != 0 && ai == 8 && bi == 15) begin
            eq = 4'h8; er = 4'h0; ez = 1'b0; eo = 1'b1;
          end else begin
            eq = 4'(sa / sb); er = 4'(sa % sb); ez = 1'b0; eo = 1'b0;
          end
          for (int i = 0; i < 3; i++) begin
            inv = 4'(int'(gq4[i]) * bi + int'(gr4[i]));
            chk($sformatf("n4[%0d] s%0d %0h/%0h quotient", i, s, ai, bi), 32'(gq4[i]), 32'(eq));
            chk($sformatf("n4[%0d] s%0d %0h/%0h remainder", i, s, ai, bi), 32'(gr4[i]), 32'(er));
            chk($sformatf("n4[%0d] s%0d %0h/%0h flags", i, s, ai, bi),
                32'({gz4[i], go4[i]}), 32'({ez, eo}));
            chk($sformatf("n4[%0d] s%0d %0h/%0h invariant", i, s, ai, bi), 32'(inv), 32'(ai));
            chk($sformatf("n4[%0d] s%0d %0h/%0h latency", i, s, ai, bi), 32'(lat4[i]),
                32'((bi == 0) ? 2 : (4 >> i) + 3));
            chk($sformatf("n4[%0d] s%0d %0h/%0h busy_profile", i, s, ai, bi), 32'(bb4[i]), 32'd0);
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
